counter_mod_updown: RTL

- Parametrised successor to the team's 4-bit free-running up counter.
- Generalised in:
  - count width;
  - modulus, via programmable terminal value;
  - direction, up/down;
  - overflow mode, wrap or saturate.
- Adds synchronous parallel load, count enable, a registered terminal-count pulse and a sticky overflow flag.
- Used as a timer/sequence counter in datapath control, and as the drop-in replacement for the fixed 4-bit counter.

---
 rtl/counter_mod_updown.sv | 79 +++++++
 1 files changed

// File: rtl/counter_mod_updown.sv
// Parametrised up/down modulo counter with load, enable, terminal-count pulse and sticky overflow.
// Replaces the fixed 4-bit free-running counter; WIDTH=4 with defaults reproduces its count sequence.
module counter_mod_updown #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int              SATURATE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  // Boundaries are detected by comparing against MAX_VAL/0 before stepping,
  // so a short modulus never relies on the natural WIDTH-bit wrap.
  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_down) begin
        if (count_q == MAX_VAL) begin
          boundary = 1'b1;
          count_d  = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // A boundary event on the same edge as a clear leaves the flag set.
  always_comb begin
    tc_d  = boundary;
    ovf_d = ovf_q;
    if (boundary) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
